// File: rtl/zion_riscv_isa_lib_bj_seq.sv
// zion_riscv_isa_lib_bj_seq: multi-cycle branch/jump resolver sharing one adder between target and link PC
module zion_riscv_isa_lib_bj_seq #(
    parameter int RV64 = 0,
    localparam int XLEN = (RV64 != 0) ? 64 : 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iVld,
    output logic            oRdy,
    input  logic            iJump,
    input  logic            iBeq,
    input  logic            iBne,
    input  logic            iBlt,
    input  logic            iBge,
    input  logic            iUnsignedFlg,
    input  logic [XLEN-1:0] iPc,
    input  logic [XLEN-1:0] iS1,
    input  logic [XLEN-1:0] iS2,
    input  logic [XLEN-1:0] iOffset,
    input  logic [1:0]      iLinkOffset,
    input  logic            iFlush,
    output logic            oVld,
    input  logic            iRdy,
    output logic            oTaken,
    output logic [XLEN-1:0] oTgtAddr,
    output logic            oLinkVld,
    output logic [XLEN-1:0] oLinkPc,
    output logic            oMisalign
);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, LINK = 2'd2, RESP = 2'd3;
    logic [1:0] state_q, state_d, lnk_q;
    logic [XLEN-1:0] pc_q, s1_q, s2_q, off_q, tgt_q, link_pc_q, add_a, add_b, sum, tgt_d;
    logic jump_q, beq_q, bne_q, blt_q, bge_q, uns_q, taken_q, link_vld_q, mis_q;
    logic accept, flush, eq, lt, taken_d;
    assign oRdy   = state_q == IDLE;
    assign accept = iVld & oRdy & ~iFlush;
    assign flush  = iFlush & (state_q != IDLE);
    always_comb begin
        add_a   = (state_q == CALC && jump_q) ? s1_q : pc_q;
        add_b   = (state_q == LINK) ? {{(XLEN-3){1'b0}}, lnk_q, 1'b0} : off_q;
        sum     = add_a + add_b;
        tgt_d   = jump_q ? {sum[XLEN-1:1], 1'b0} : sum;
        eq      = s1_q == s2_q;
        lt      = $signed({~uns_q & s1_q[XLEN-1], s1_q}) < $signed({~uns_q & s2_q[XLEN-1], s2_q});
        taken_d = jump_q | (beq_q & eq) | (bne_q & ~eq) | (blt_q & lt) | (bge_q & ~lt);
        state_d = flush ? IDLE :
                  state_q == IDLE ? (accept ? CALC : IDLE) :
                  state_q == CALC ? (jump_q ? LINK : RESP) :
                  state_q == LINK ? RESP :
                  (iRdy ? IDLE : RESP);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            off_q      <= '0;
            lnk_q      <= '0;
            jump_q     <= 1'b0;
            beq_q      <= 1'b0;
            bne_q      <= 1'b0;
            blt_q      <= 1'b0;
            bge_q      <= 1'b0;
            uns_q      <= 1'b0;
            tgt_q      <= '0;
            taken_q    <= 1'b0;
            mis_q      <= 1'b0;
            link_pc_q  <= '0;
            link_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q       <= iPc;
                s1_q       <= iS1;
                s2_q       <= iS2;
                off_q      <= iOffset;
                lnk_q      <= iLinkOffset;
                jump_q     <= iJump;
                beq_q      <= iBeq;
                bne_q      <= iBne;
                blt_q      <= iBlt;
                bge_q      <= iBge;
                uns_q      <= iUnsignedFlg;
                link_pc_q  <= '0;
                link_vld_q <= 1'b0;
            end else if (flush) begin
                taken_q    <= 1'b0;
                link_vld_q <= 1'b0;
                mis_q      <= 1'b0;
            end else if (state_q == CALC) begin
                tgt_q   <= tgt_d;
                taken_q <= taken_d;
                mis_q   <= taken_d & tgt_d[1];
            end else if (state_q == LINK) begin
                link_pc_q  <= sum;
                link_vld_q <= 1'b1;
            end
        end
    end
    assign oVld      = state_q == RESP;
    assign oTaken    = taken_q;
    assign oTgtAddr  = tgt_q;
    assign oLinkVld  = link_vld_q;
    assign oLinkPc   = link_pc_q;
    assign oMisalign = mis_q;
    assert property (@(posedge clk) disable iff (!rst_n) accept |-> $onehot0({iJump, iBeq, iBne, iBlt, iBge}));
endmodule
